// File: rtl/sparse_tile_matmul.sv
// Tiled N x N signed matrix multiply C = A*B (or C += A*B) with optional
// zero-operand MAC skipping; one (tr,tc,k,i,j) point is processed per cycle.
module sparse_tile_matmul #(
    parameter int N    = 16,
    parameter int TILE = 4,
    parameter int DW   = 16,
    parameter int AW   = 32,
    localparam int IW  = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          skip_en,
    input  logic          acc_mode,
    input  logic          a_we,
    input  logic          b_we,
    input  logic [IW-1:0] wr_row,
    input  logic [IW-1:0] wr_col,
    input  logic [DW-1:0] wr_data,
    input  logic [IW-1:0] c_rd_row,
    input  logic [IW-1:0] c_rd_col,
    output logic [AW-1:0] c_rd_data,
    output logic          busy,
    output logic          done,
    output logic [31:0]   cycle_count,
    output logic [31:0]   mac_count,
    output logic [31:0]   skipped_mac_count
);

    // state | meaning
    // IDLE  | waiting for start; operand stores writable
    // RUN   | one MAC point per cycle, N^3 cycles
    // DONE  | single-cycle completion pulse; operand stores writable
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

    localparam logic [IW-1:0] T_LAST = IW'(TILE - 1);
    localparam logic [IW-1:0] N_LAST = IW'(N - 1);
    localparam logic [IW-1:0] T_EDGE = IW'(N - TILE);
    localparam logic [IW-1:0] T_STEP = IW'(TILE);

    state_t state_q, state_d;
    logic [IW-1:0] tr_q, tr_d, tc_q, tc_d, k_q, k_d, i_q, i_d, j_q, j_d;
    logic skip_q, skip_d, accm_q, accm_d;
    logic [31:0] cyc_q, cyc_d, mac_q, mac_d, skp_q, skp_d;
    logic [AW-1:0] c_rd_q;

    logic signed [DW-1:0] a_mem_q [N][N];
    logic signed [DW-1:0] b_mem_q [N][N];
    logic [AW-1:0]        c_mem_q [N][N];

    logic [IW-1:0]          r_idx, c_idx;
    logic signed [DW-1:0]   a_op, b_op;
    logic signed [2*DW-1:0] prod;
    logic [AW-1:0]          prod_ext, acc_in, c_wdata;
    logic                   is_skip, last_pt, c_we;

    assign r_idx    = tr_q + i_q;
    assign c_idx    = tc_q + j_q;
    assign a_op     = a_mem_q[r_idx][k_q];
    assign b_op     = b_mem_q[k_q][c_idx];
    assign prod     = (2*DW)'(a_op) * (2*DW)'(b_op);
    assign prod_ext = AW'(prod);
    assign acc_in   = (k_q == '0 && !accm_q) ? '0 : c_mem_q[r_idx][c_idx];
    assign is_skip  = skip_q && (a_op == '0 || b_op == '0);
    assign last_pt  = (j_q == T_LAST) && (i_q == T_LAST) && (k_q == N_LAST) &&
                      (tc_q == T_EDGE) && (tr_q == T_EDGE);

    always_comb begin
        state_d = state_q;
        tr_d    = tr_q;
        tc_d    = tc_q;
        k_d     = k_q;
        i_d     = i_q;
        j_d     = j_q;
        skip_d  = skip_q;
        accm_d  = accm_q;
        cyc_d   = cyc_q;
        mac_d   = mac_q;
        skp_d   = skp_q;
        c_we    = 1'b0;
        c_wdata = '0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    skip_d  = skip_en;
                    accm_d  = acc_mode;
                    cyc_d   = '0;
                    mac_d   = '0;
                    skp_d   = '0;
                    tr_d    = '0;
                    tc_d    = '0;
                    k_d     = '0;
                    i_d     = '0;
                    j_d     = '0;
                end
            end
            RUN: begin
                cyc_d = cyc_q + 32'd1;
                c_we  = 1'b1;
                if (is_skip) begin
                    c_wdata = acc_in;
                    skp_d   = skp_q + 32'd1;
                end else begin
                    c_wdata = acc_in + prod_ext;
                    mac_d   = mac_q + 32'd1;
                end
                // Nested loop advance, j fastest, tiles outermost.
                j_d = j_q + 1'b1;
                if (j_q == T_LAST) begin
                    j_d = '0;
                    i_d = i_q + 1'b1;
                    if (i_q == T_LAST) begin
                        i_d = '0;
                        k_d = k_q + 1'b1;
                        if (k_q == N_LAST) begin
                            k_d  = '0;
                            tc_d = tc_q + T_STEP;
                            if (tc_q == T_EDGE) begin
                                tc_d = '0;
                                tr_d = tr_q + T_STEP;
                                if (tr_q == T_EDGE) tr_d = '0;
                            end
                        end
                    end
                end
                if (last_pt) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            tr_q    <= '0;
            tc_q    <= '0;
            k_q     <= '0;
            i_q     <= '0;
            j_q     <= '0;
            skip_q  <= 1'b0;
            accm_q  <= 1'b0;
            cyc_q   <= '0;
            mac_q   <= '0;
            skp_q   <= '0;
            c_rd_q  <= '0;
            for (int r = 0; r < N; r++)
                for (int c = 0; c < N; c++)
                    c_mem_q[r][c] <= '0;
        end else begin
            state_q <= state_d;
            tr_q    <= tr_d;
            tc_q    <= tc_d;
            k_q     <= k_d;
            i_q     <= i_d;
            j_q     <= j_d;
            skip_q  <= skip_d;
            accm_q  <= accm_d;
            cyc_q   <= cyc_d;
            mac_q   <= mac_d;
            skp_q   <= skp_d;
            c_rd_q  <= c_mem_q[c_rd_row][c_rd_col];
            if (c_we) c_mem_q[r_idx][c_idx] <= c_wdata;
        end
    end

    // Operand stores keep their contents through reset.
    always_ff @(posedge clk) begin
        if (state_q != RUN) begin
            if (a_we) a_mem_q[wr_row][wr_col] <= wr_data;
            if (b_we) b_mem_q[wr_row][wr_col] <= wr_data;
        end
    end

    assign busy              = (state_q == RUN);
    assign done              = (state_q == DONE);
    assign c_rd_data         = c_rd_q;
    assign cycle_count       = cyc_q;
    assign mac_count         = mac_q;
    assign skipped_mac_count = skp_q;

endmodule

// File: tb/tb_sparse_tile_matmul.sv
// Scoreboard bench for sparse_tile_matmul (N=4, TILE=2): expected stats and
// C reads are queued at stimulus time and compared by independent monitors.
module tb_sparse_tile_matmul;
    localparam int N = 4, TILE = 2, DW = 16, AW = 32, IW = 2;
    localparam int NPTS = N * N * N;

    logic clk = 1'b0;
    logic rst, start, skip_en, acc_mode, a_we, b_we;
    logic [IW-1:0] wr_row, wr_col, c_rd_row, c_rd_col;
    logic [DW-1:0] wr_data;
    logic [AW-1:0] c_rd_data;
    logic busy, done;
    logic [31:0] cycle_count, mac_count, skipped_mac_count;

    sparse_tile_matmul #(.N(N), .TILE(TILE), .DW(DW), .AW(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .skip_en(skip_en), .acc_mode(acc_mode),
        .a_we(a_we), .b_we(b_we), .wr_row(wr_row), .wr_col(wr_col), .wr_data(wr_data),
        .c_rd_row(c_rd_row), .c_rd_col(c_rd_col), .c_rd_data(c_rd_data),
        .busy(busy), .done(done), .cycle_count(cycle_count), .mac_count(mac_count),
        .skipped_mac_count(skipped_mac_count)
    );

    always #5 clk = ~clk;

    typedef struct { int cyc; int mac; int skp; } stats_t;

    int errors = 0, checks = 0;
    int rd_q[$];
    stats_t done_q[$];
    logic rd_req = 1'b0;
    int a_m[N][N], b_m[N][N], c_m[N][N];

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Read monitor: data for an address presented before an edge appears after it.
    initial forever begin
        @(posedge clk);
        if (rd_req) begin
            #1;
            if (rd_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL c_rd_underflow: got read with empty queue expected none");
            end else begin
                check("c_rd_data", longint'($signed(c_rd_data)), longint'(rd_q.pop_front()));
            end
        end
    end

    // Done monitor.
    initial forever begin
        @(posedge clk);
        #1;
        if (done) begin
            if (done_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_done: got done=1 expected no done");
            end else begin
                stats_t s;
                s = done_q.pop_front();
                check("cycle_count", cycle_count, s.cyc);
                check("mac_count", mac_count, s.mac);
                check("skipped_mac_count", skipped_mac_count, s.skp);
                check("busy_at_done", busy, 0);
            end
        end
    end

    task automatic load_ab();
        for (int m = 0; m < 2; m++)
            for (int r = 0; r < N; r++)
                for (int c = 0; c < N; c++) begin
                    @(negedge clk);
                    a_we = (m == 0); b_we = (m == 1);
                    wr_row = IW'(r); wr_col = IW'(c);
                    wr_data = DW'((m == 0) ? a_m[r][c] : b_m[r][c]);
                end
        @(negedge clk);
        a_we = 1'b0; b_we = 1'b0;
    endtask

    task automatic read_all();
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                @(negedge clk);
                c_rd_row = IW'(r); c_rd_col = IW'(c);
                rd_q.push_back(c_m[r][c]);
                rd_req = 1'b1;
            end
        @(negedge clk);
        rd_req = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    // abort_at: RUN edge at which reset is sampled (0 = none).
    // disturb: pulse start and write A during the run; wiggle skip/acc modes.
    task automatic run(input bit skp, input bit acc, input int abort_at, input bit disturb);
        int sk, n;
        int nc[N][N];
        stats_t s;
        sk = 0;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                int sum;
                sum = acc ? c_m[r][c] : 0;
                for (int k = 0; k < N; k++) begin
                    if (a_m[r][k] == 0 || b_m[k][c] == 0) sk++;
                    sum += a_m[r][k] * b_m[k][c];
                end
                nc[r][c] = sum;
            end
        s.cyc = NPTS;
        s.skp = skp ? sk : 0;
        s.mac = NPTS - s.skp;
        if (abort_at == 0) done_q.push_back(s);

        @(negedge clk);
        start = 1'b1; skip_en = skp; acc_mode = acc;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        if (disturb) begin skip_en = ~skp; acc_mode = ~acc; end
        n = 0;
        for (int e = 1; e <= NPTS + 20; e++) begin
            @(posedge clk);
            #1;
            n = e;
            if (abort_at != 0 && e == abort_at - 1) rst = 1'b0;
            if (abort_at != 0 && e == abort_at) break;
            if (done) break;
            if (disturb && e == 10) begin
                start = 1'b1; a_we = 1'b1; wr_row = '0; wr_col = '0; wr_data = 16'd5;
            end
            if (disturb && e == 12) begin
                start = 1'b0; a_we = 1'b0;
            end
        end

        if (abort_at != 0) begin
            check("abort_busy", busy, 0);
            check("abort_done", done, 0);
            check("abort_cycle_count", cycle_count, 0);
            check("abort_mac_count", mac_count, 0);
            check("abort_skipped_count", skipped_mac_count, 0);
            check("abort_c_rd_data", c_rd_data, 0);
            rst = 1'b1;
            for (int r = 0; r < N; r++)
                for (int c = 0; c < N; c++) c_m[r][c] = 0;
        end else begin
            check("done_latency", n, NPTS);
            @(posedge clk);
            #1;
            check("done_one_cycle", done, 0);
            check("idle_busy", busy, 0);
            for (int r = 0; r < N; r++)
                for (int c = 0; c < N; c++) c_m[r][c] = nc[r][c];
        end
        a_we = 1'b0; start = 1'b0;
    endtask

    task automatic set_req031();
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                a_m[r][c] = (r == c) ? 1 : 0;
                b_m[r][c] = 4 * r + c + 1;
            end
    endtask

    task automatic set_const(input int av, input int bv);
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                a_m[r][c] = av;
                b_m[r][c] = bv;
            end
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; skip_en = 1'b0; acc_mode = 1'b0;
        a_we = 1'b0; b_we = 1'b0; wr_row = '0; wr_col = '0; wr_data = '0;
        c_rd_row = '0; c_rd_col = '0;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) c_m[r][c] = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_cycle_count", cycle_count, 0);
        check("rst_mac_count", mac_count, 0);
        check("rst_skipped_count", skipped_mac_count, 0);
        check("rst_c_rd_data", c_rd_data, 0);
        @(negedge clk);
        rst = 1'b1;
        read_all();

        set_req031(); load_ab();
        run(1'b1, 1'b0, 0, 1'b0); read_all();
        run(1'b0, 1'b0, 0, 1'b0); read_all();

        set_const(-1, 32767); load_ab();
        run(1'b1, 1'b0, 0, 1'b0); read_all();
        check("req033_first", c_m[2][1], -131068);
        run(1'b1, 1'b1, 0, 1'b0); read_all();
        check("req033_second", c_m[3][3], -262136);

        set_const(-32768, -32768); load_ab();
        run(1'b0, 1'b0, 0, 1'b0); read_all();

        set_req031(); load_ab();
        run(1'b1, 1'b0, 20, 1'b0); read_all();
        repeat (NPTS + 5) @(negedge clk);
        run(1'b1, 1'b0, 0, 1'b0); read_all();

        run(1'b1, 1'b0, 0, 1'b1); read_all();

        for (int t = 0; t < 3; t++) begin
            for (int r = 0; r < N; r++)
                for (int c = 0; c < N; c++) begin
                    a_m[r][c] = ($urandom_range(0, 2) == 0) ? 0 : int'(shortint'($urandom));
                    b_m[r][c] = ($urandom_range(0, 2) == 0) ? 0 : int'(shortint'($urandom));
                end
            load_ab();
            run(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, 1'b1);
            read_all();
        end

        repeat (4) @(negedge clk);
        if (done_q.size() != 0 || rd_q.size() != 0) begin
            checks++; errors++;
            $display("FAIL scoreboard_leftover: got %0d pending expected 0", done_q.size() + rd_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
